// File: rtl/l2_arb_pkg.sv
// Shared constants and helpers for the L2 request arbiter.
// Default geometry: 8 requesters, 26-bit line address, 128-bit line, 52-bit tag.
package l2_arb_pkg;

  localparam int L2_ARB_ADDR_W   = 26;
  localparam int L2_ARB_DATA_W   = 128;
  localparam int L2_ARB_TAG_W    = 52;
  localparam int L2_ARB_NUM_REQS = 8;

  // Requester index width; never zero so a single-bit field always exists.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int L2_ARB_IDX_W = idx_width(L2_ARB_NUM_REQS);

  typedef logic [L2_ARB_TAG_W+L2_ARB_IDX_W-1:0] l2_mem_tag_t;

  // Memory-side tag layout at the default geometry: requester index in the LSBs.
  function automatic l2_mem_tag_t pack_tag(input logic [L2_ARB_TAG_W-1:0] tag,
                                           input logic [L2_ARB_IDX_W-1:0] idx);
    return {tag, idx};
  endfunction

  function automatic logic [L2_ARB_IDX_W-1:0] unpack_idx(input l2_mem_tag_t t);
    return t[L2_ARB_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, priority rotating
// to the slot after the most recent winner each time advance_i is strobed.
module rr_arbiter
  import l2_arb_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = idx_width(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  valid_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;

  // Scan rr_ptr+1, rr_ptr+2, ... modulo N and grant the first valid slot.
  always_comb begin
    int   cand;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(rr_ptr_q) + k) % N;
      if (!found && valid_i[cand[IW-1:0]]) begin
        found                   = 1'b1;
        grant_o[cand[IW-1:0]]   = 1'b1;
        idx_o                   = cand[IW-1:0];
      end
    end
  end

  // Pointer follows the winner only when the grant is actually consumed.
  always_comb begin
    rr_ptr_d = advance_i ? idx_o : rr_ptr_q;
  end

  // Reset to N-1 so requester 0 holds first priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_q <= IW'(N - 1);
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/l2_req_arbiter.sv
// Shares the L2 request port among NUM_REQS requesters (even = icache,
// odd = dcache) through a round-robin arbiter and a one-entry output
// register; responses are steered back by the index carried in the tag LSBs.
// Optional per-requester grant counters: define L2_ARB_STATS_EN.
module l2_req_arbiter
  import l2_arb_pkg::*;
#(
  parameter int NUM_REQS   = 8,
  parameter int ADDR_WIDTH = L2_ARB_ADDR_W,
  parameter int DATA_WIDTH = L2_ARB_DATA_W,
  parameter int TAG_WIDTH  = L2_ARB_TAG_W,
  parameter int IDX_WIDTH  = idx_width(NUM_REQS)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQS-1:0]                 req_valid_i,
  input  logic [NUM_REQS-1:0]                 req_rw_i,
  input  logic [NUM_REQS*DATA_WIDTH/8-1:0]    req_byteen_i,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]      req_data_i,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]       req_tag_i,
  output logic [NUM_REQS-1:0]                 req_ready_o,
  output logic                                mem_req_valid_o,
  output logic                                mem_req_rw_o,
  output logic [DATA_WIDTH/8-1:0]             mem_req_byteen_o,
  output logic [ADDR_WIDTH-1:0]               mem_req_addr_o,
  output logic [DATA_WIDTH-1:0]               mem_req_data_o,
  output logic [TAG_WIDTH+IDX_WIDTH-1:0]      mem_req_tag_o,
  input  logic                                mem_req_ready_i,
  input  logic                                mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]               mem_rsp_data_i,
  input  logic [TAG_WIDTH+IDX_WIDTH-1:0]      mem_rsp_tag_i,
  output logic                                mem_rsp_ready_o,
  output logic [NUM_REQS-1:0]                 rsp_valid_o,
  output logic [DATA_WIDTH-1:0]               rsp_data_o,
  output logic [TAG_WIDTH-1:0]                rsp_tag_o,
  input  logic [NUM_REQS-1:0]                 rsp_ready_i
`ifdef L2_ARB_STATS_EN
  ,
  output logic [NUM_REQS*32-1:0]              grant_cnt_o
`endif
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int MTAG_W = TAG_WIDTH + IDX_WIDTH;

  logic [NUM_REQS-1:0]  grant;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 load;

  logic                 out_valid_q, out_valid_d;
  logic                 rw_q, rw_d;
  logic [BE_W-1:0]      byteen_q, byteen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [MTAG_W-1:0]    tag_q, tag_d;

  rr_arbiter #(
    .N  (NUM_REQS),
    .IW (IDX_WIDTH)
  ) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (req_valid_i),
    .advance_i (load),
    .grant_o   (grant),
    .idx_o     (win_idx)
  );

  // Accept whenever there is a winner and the output slot is empty or draining.
  always_comb begin
    load        = (|grant) & (~out_valid_q | mem_req_ready_i);
    req_ready_o = grant & {NUM_REQS{load}};
  end

  // Output-slot next state: capture the winner, or free the slot once L2 takes it.
  always_comb begin
    out_valid_d = out_valid_q;
    rw_d        = rw_q;
    byteen_d    = byteen_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tag_d       = tag_q;
    if (load) begin
      out_valid_d = 1'b1;
      rw_d        = req_rw_i[win_idx];
      byteen_d    = req_byteen_i[int'(win_idx)*BE_W +: BE_W];
      addr_d      = req_addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      data_d      = req_data_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      tag_d       = {req_tag_i[int'(win_idx)*TAG_WIDTH +: TAG_WIDTH], win_idx};
    end else if (mem_req_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; reset discards any request still waiting for L2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      rw_q        <= 1'b0;
      byteen_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tag_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rw_q        <= rw_d;
      byteen_q    <= byteen_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
    end
  end

  assign mem_req_valid_o  = out_valid_q;
  assign mem_req_rw_o     = rw_q;
  assign mem_req_byteen_o = byteen_q;
  assign mem_req_addr_o   = addr_q;
  assign mem_req_data_o   = data_q;
  assign mem_req_tag_o    = tag_q;

  // ---------------- response demux ----------------
  logic [IDX_WIDTH-1:0] rsp_idx;
  logic                 rsp_idx_ok;

  assign rsp_idx = mem_rsp_tag_i[IDX_WIDTH-1:0];

  // Only a non-power-of-two requester count can produce an unmapped index.
  if ((1 << IDX_WIDTH) == NUM_REQS) begin : g_idx_full
    assign rsp_idx_ok = 1'b1;
  end else begin : g_idx_part
    assign rsp_idx_ok = ({1'b0, rsp_idx} < (IDX_WIDTH+1)'(NUM_REQS));
  end

  // Steer valid to the tagged requester; unmapped responses are swallowed.
  always_comb begin
    rsp_valid_o     = '0;
    mem_rsp_ready_o = 1'b1;
    if (rsp_idx_ok) begin
      rsp_valid_o[rsp_idx] = mem_rsp_valid_i;
      mem_rsp_ready_o      = rsp_ready_i[rsp_idx];
    end
  end

  assign rsp_data_o = mem_rsp_data_i;
  assign rsp_tag_o  = mem_rsp_tag_i[MTAG_W-1:IDX_WIDTH];

  a_rsp_idx_range : assert property (@(posedge clk_i) disable iff (rst_i)
    mem_rsp_valid_i |-> rsp_idx_ok)
    else $error("l2_req_arbiter: response index out of range");

`ifdef L2_ARB_STATS_EN
  // Per-requester saturating grant counters.
  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_cnt
    logic [31:0] cnt_q, cnt_d;

    // Count loads won by this requester, sticking at all-ones.
    always_comb begin
      cnt_d = cnt_q;
      if (load && grant[gi] && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign grant_cnt_o[gi*32 +: 32] = cnt_q;
  end
`endif

endmodule
